// File: rtl/xbar_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : xbar_arb_pkg                                         |
// | Description : Shared types and constants for the cross-bar         |
// |               per-slave-port arbiter (state encoding, master       |
// |               indices, slave-select bit position).                 |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package xbar_arb_pkg;

   // Arbiter states; YIELD is only reachable with the burst limit built in
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN   = 2'd1,
      YIELD = 2'd2
   } arb_state_e;

   // Master indices as stored in the owner / last-owner registers
   localparam logic M1 = 1'b0;
   localparam logic M2 = 1'b1;

   // Slave-select bit position for the default 32-bit address map
   localparam int SEL_BIT = 31;

endpackage
`default_nettype wire

// File: rtl/xbar_slave_arbiter_rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : rr_pick2                                             |
// | Description : Combinational two-input round-robin pick. On         |
// |               contention the master that did not own last wins.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module rr_pick2
   import xbar_arb_pkg::*;
(
   input  logic q1_i,
   input  logic q2_i,
   input  logic last_owner_i,
   output logic winner_o
);

   // Pick the lone requester, or alternate away from the last owner
   always_comb begin
      winner_o = M1;
      if (q1_i && q2_i) begin
         winner_o = ~last_owner_i;
      end else if (q2_i) begin
         winner_o = M2;
      end
   end

endmodule
`default_nettype wire

// File: rtl/xbar_slave_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : xbar_slave_arbiter                                   |
// | Description : Per-slave-port arbiter for the 2x2 cross bar. Grants |
// |               one master at a time, holds it for a burst, routes   |
// |               ack/rdata back to the owner, round-robin on clash.   |
// |               Optional burst limit: XBAR_ARB_BURST_LIMIT_EN.       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module xbar_slave_arbiter
   import xbar_arb_pkg::*;
#(
   parameter int   ADDR_W    = 32,
   parameter int   DATA_W    = 32,
   parameter logic SLAVE_SEL = 1'b0,
   parameter int   MAX_BURST = 4
)(
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              master_1_req,
   input  logic              master_2_req,
   input  logic              master_1_cmd,
   input  logic              master_2_cmd,
   input  logic [ADDR_W-1:0] master_1_addr,
   input  logic [ADDR_W-1:0] master_2_addr,
   input  logic [DATA_W-1:0] master_1_wdata,
   input  logic [DATA_W-1:0] master_2_wdata,
   output logic              master_1_ack,
   output logic              master_2_ack,
   output logic [DATA_W-1:0] master_1_rdata,
   output logic [DATA_W-1:0] master_2_rdata,
   output logic              slave_req,
   output logic              slave_cmd,
   output logic [ADDR_W-1:0] slave_addr,
   output logic [DATA_W-1:0] slave_wdata,
   input  logic              slave_ack,
   input  logic [DATA_W-1:0] slave_rdata
);

   localparam int C_SEL = (ADDR_W == 32) ? SEL_BIT : ADDR_W - 1;

   arb_state_e        state_q;
   logic              owner_q;
   logic              last_owner_q;
   logic [DATA_W-1:0] rdata_1_q;
   logic [DATA_W-1:0] rdata_2_q;

   logic w_q1, w_q2, w_own_q, w_oth_q, w_owned, w_winner;

   // A request only counts for this port when its select bit matches
   assign w_q1    = master_1_req & (master_1_addr[C_SEL] == SLAVE_SEL);
   assign w_q2    = master_2_req & (master_2_addr[C_SEL] == SLAVE_SEL);
   assign w_own_q = (owner_q == M2) ? w_q2 : w_q1;
   assign w_oth_q = (owner_q == M2) ? w_q1 : w_q2;
   assign w_owned = (state_q == OWN);

   rr_pick2 u_pick (
      .q1_i         (w_q1),
      .q2_i         (w_q2),
      .last_owner_i (last_owner_q),
      .winner_o     (w_winner)
   );

`ifdef XBAR_ARB_BURST_LIMIT_EN
   localparam int CNT_W = ($clog2(MAX_BURST + 1) > 3) ? $clog2(MAX_BURST + 1) : 3;
   localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] C_MAX_M1 = CNT_W'(MAX_BURST - 1);

   logic [CNT_W-1:0] ack_cnt_q;
   logic             w_limit;

   // Yield once the owner has had its quota and the other master waits
   assign w_limit = w_oth_q &&
                    ((ack_cnt_q >= C_MAX) || (slave_ack && (ack_cnt_q == C_MAX_M1)));
`else
   logic w_unused_burst;
   assign w_unused_burst = (MAX_BURST > 0);
`endif

   // Arbiter state machine: grant from IDLE/YIELD, release on owner drop
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q      <= IDLE;
         owner_q      <= M1;
         last_owner_q <= M2;
`ifdef XBAR_ARB_BURST_LIMIT_EN
         ack_cnt_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE, YIELD: begin
               // YIELD behaves like a one-cycle IDLE; rr_pick2 steers to the other master
               if (w_q1 || w_q2) begin
                  state_q   <= OWN;
                  owner_q   <= w_winner;
`ifdef XBAR_ARB_BURST_LIMIT_EN
                  ack_cnt_q <= '0;
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            OWN: begin
               if (!w_own_q) begin
                  state_q      <= IDLE;
                  last_owner_q <= owner_q;
               end
`ifdef XBAR_ARB_BURST_LIMIT_EN
               else if (w_limit) begin
                  state_q      <= YIELD;
                  last_owner_q <= owner_q;
               end else if (slave_ack && (ack_cnt_q < C_MAX)) begin
                  ack_cnt_q <= ack_cnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Track the last read data seen by each master while it owned the slave
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         rdata_1_q <= '0;
         rdata_2_q <= '0;
      end else if (w_owned) begin
         if (owner_q == M2) rdata_2_q <= slave_rdata;
         else               rdata_1_q <= slave_rdata;
      end
   end

   // Steer the owner's request to the slave and the slave's response back
   always_comb begin
      slave_req      = 1'b0;
      slave_cmd      = 1'b0;
      slave_addr     = '0;
      slave_wdata    = '0;
      master_1_ack   = 1'b0;
      master_2_ack   = 1'b0;
      master_1_rdata = rdata_1_q;
      master_2_rdata = rdata_2_q;
      if (w_owned) begin
         slave_req = w_own_q;
         if (owner_q == M2) begin
            slave_cmd      = master_2_cmd;
            slave_addr     = master_2_addr;
            slave_wdata    = master_2_wdata;
            master_2_ack   = slave_ack;
            master_2_rdata = slave_rdata;
         end else begin
            slave_cmd      = master_1_cmd;
            slave_addr     = master_1_addr;
            slave_wdata    = master_1_wdata;
            master_1_ack   = slave_ack;
            master_1_rdata = slave_rdata;
         end
      end
   end

endmodule
`default_nettype wire
